// File: rtl/sim_ctrl_pkg.sv
// Shared constants for the simulation-control slave: register offsets,
// CTRL/STATUS bit positions, the dump FSM states and the byte-enable merge helper.
package sim_ctrl_pkg;

    localparam logic [2:0] OFF_CTRL      = 3'd0;
    localparam logic [2:0] OFF_FAIL_NUM  = 3'd1;
    localparam logic [2:0] OFF_SIG_BEGIN = 3'd2;
    localparam logic [2:0] OFF_SIG_END   = 3'd3;
    localparam logic [2:0] OFF_STATUS    = 3'd4;

    localparam int CTRL_END_BIT  = 0;
    localparam int CTRL_SUCC_BIT = 1;
    localparam int CTRL_DUMP_BIT = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_END_BIT  = 2;
    localparam int STAT_SUCC_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sim_sig_reader.sv
// Signature dump engine: walks [begin, end) one word at a time over the
// master port and presents each word on a valid/ready stream.
module sim_sig_reader
    import sim_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int SIG_MAX_WORDS = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] sig_begin_i,
    input  logic [ADDR_W-1:0] sig_end_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              sig_valid_o,
    output logic [31:0]       sig_data_o,
    input  logic              sig_ready_i,
    output logic              dump_done_o
);

    localparam int CNT_W = $clog2(SIG_MAX_WORDS + 1);

    dump_state_e       state_r, state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       data_r;
    logic              zero_done_r;
    logic [ADDR_W-1:0] begin_al_s, end_al_s, words_s;
    logic [CNT_W-1:0]  start_cnt_s;
    logic              unused_low_s;

    assign begin_al_s   = {sig_begin_i[ADDR_W-1:2], 2'b00};
    assign end_al_s     = {sig_end_i[ADDR_W-1:2], 2'b00};
    assign words_s      = (end_al_s - begin_al_s) >> 2'd2;
    assign unused_low_s = ^{sig_begin_i[1:0], sig_end_i[1:0]};

    // Word count of the requested range; an inverted range is empty, not wrapped.
    always_comb begin
        start_cnt_s = '0;
        if (end_al_s <= begin_al_s) begin
            start_cnt_s = '0;
        end else if (words_s > ADDR_W'(SIG_MAX_WORDS)) begin
            start_cnt_s = CNT_W'(SIG_MAX_WORDS);
        end else begin
            start_cnt_s = CNT_W'(words_s);
        end
    end

    // Next-state logic for the dump walk.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i && (start_cnt_s != '0)) state_s = ST_REQ;
                else                                state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_gnt_i) state_s = ST_WAIT;
                else           state_s = ST_REQ;
            end
            ST_WAIT: begin
                if (mem_rvalid_i) state_s = ST_OUT;
                else              state_s = ST_WAIT;
            end
            ST_OUT: begin
                if (sig_ready_i && (cnt_r == CNT_W'(1))) state_s = ST_DONE;
                else if (sig_ready_i)                    state_s = ST_REQ;
                else                                     state_s = ST_OUT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus pointer, remaining count and captured read word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            cnt_r       <= '0;
            data_r      <= 32'h0;
            zero_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            zero_done_r <= (state_r == ST_IDLE) && start_i && (start_cnt_s == '0);
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        ptr_r <= begin_al_s;
                        cnt_r <= start_cnt_s;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) data_r <= mem_rdata_i;
                end
                ST_OUT: begin
                    if (sig_ready_i) begin
                        ptr_r <= ptr_r + ADDR_W'(4);
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    ptr_r <= ptr_r;
                end
            endcase
        end
    end

    // Outputs decode straight from state so a reset drops them immediately.
    always_comb begin
        busy_o      = (state_r != ST_IDLE);
        mem_req_o   = (state_r == ST_REQ);
        sig_valid_o = (state_r == ST_OUT);
        dump_done_o = (state_r == ST_DONE) || zero_done_r;
        if (mem_req_o) mem_addr_o = ptr_r;
        else           mem_addr_o = '0;
        if (sig_valid_o) sig_data_o = data_r;
        else             sig_data_o = 32'h0;
    end

endmodule

// File: rtl/sim_ctrl_dev.sv
// Simulation-control slave: test status registers, signature bounds and the
// STATUS view, with the dump walk delegated to sim_sig_reader.
module sim_ctrl_dev
    import sim_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int SIG_MAX_WORDS = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              sig_valid_o,
    output logic [31:0]       sig_data_o,
    input  logic              sig_ready_i,
    output logic              sim_end_o,
    output logic              sim_succ_o,
    output logic [31:0]       fail_num_o,
    output logic              dump_done_o
);

    logic [2:0]  off_s;
    logic        wr_s, rd_s, start_s, busy_s, done_s, unused_addr_s;
    logic [31:0] fail_num_r, sig_begin_r, sig_end_r;
    logic        sim_end_r, sim_succ_r, done_sticky_r;
    logic        rvalid_r, rd_r;
    logic [2:0]  rd_off_r;

    assign off_s         = addr_i[4:2];
    assign unused_addr_s = ^{addr_i[ADDR_W-1:5], addr_i[1:0]};
    assign wr_s          = req_i && we_i;
    assign rd_s          = req_i && !we_i;
    assign gnt_o         = req_i;
    assign start_s       = wr_s && (off_s == OFF_CTRL) && be_i[0]
                           && wdata_i[CTRL_DUMP_BIT] && !busy_s;

    // Register file, sticky status and the one-cycle response pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_num_r    <= 32'h0;
            sig_begin_r   <= 32'h0;
            sig_end_r     <= 32'h0;
            sim_end_r     <= 1'b0;
            sim_succ_r    <= 1'b0;
            done_sticky_r <= 1'b0;
            rvalid_r      <= 1'b0;
            rd_r          <= 1'b0;
            rd_off_r      <= 3'd0;
        end else begin
            rvalid_r <= req_i;
            rd_r     <= rd_s;
            rd_off_r <= off_s;
            if (wr_s) begin
                case (off_s)
                    OFF_CTRL: begin
                        if (be_i[0] && wdata_i[CTRL_END_BIT] && !sim_end_r) begin
                            sim_end_r  <= 1'b1;
                            sim_succ_r <= wdata_i[CTRL_SUCC_BIT];
                        end
                    end
                    OFF_FAIL_NUM:  fail_num_r <= be_merge(fail_num_r, wdata_i, be_i);
                    OFF_SIG_BEGIN: if (!busy_s) sig_begin_r <= be_merge(sig_begin_r, wdata_i, be_i);
                    OFF_SIG_END:   if (!busy_s) sig_end_r <= be_merge(sig_end_r, wdata_i, be_i);
                    default:       fail_num_r <= fail_num_r;
                endcase
            end
            if (start_s)     done_sticky_r <= 1'b0;
            else if (done_s) done_sticky_r <= 1'b1;
        end
    end

    // Read data is taken in the response cycle, so a read racing the final
    // handshake still reports busy and the following one sees done.
    always_comb begin
        rdata_o = 32'h0;
        if (rvalid_r && rd_r) begin
            case (rd_off_r)
                OFF_FAIL_NUM:  rdata_o = fail_num_r;
                OFF_SIG_BEGIN: rdata_o = sig_begin_r;
                OFF_SIG_END:   rdata_o = sig_end_r;
                OFF_STATUS: begin
                    rdata_o[STAT_BUSY_BIT] = busy_s;
                    rdata_o[STAT_DONE_BIT] = done_sticky_r;
                    rdata_o[STAT_END_BIT]  = sim_end_r;
                    rdata_o[STAT_SUCC_BIT] = sim_succ_r;
                end
                default:       rdata_o = 32'h0;
            endcase
        end else begin
            rdata_o = 32'h0;
        end
    end

    assign rvalid_o    = rvalid_r;
    assign sim_end_o   = sim_end_r;
    assign sim_succ_o  = sim_succ_r;
    assign fail_num_o  = fail_num_r;
    assign dump_done_o = done_s;

    sim_sig_reader #(
        .ADDR_W        (ADDR_W),
        .SIG_MAX_WORDS (SIG_MAX_WORDS)
    ) u_reader (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_s),
        .sig_begin_i  (ADDR_W'(sig_begin_r)),
        .sig_end_i    (ADDR_W'(sig_end_r)),
        .busy_o       (busy_s),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .sig_valid_o  (sig_valid_o),
        .sig_data_o   (sig_data_o),
        .sig_ready_i  (sig_ready_i),
        .dump_done_o  (done_s)
    );

endmodule

// File: tb/tb_sim_ctrl_dev.sv
// Bench for sim_ctrl_dev: a RAM/sink responder, a per-cycle compare against a
// register/stream model, and directed scenarios with literal expectations.
module tb_sim_ctrl_dev;

    logic        clk, rst, req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_rdata, sig_data, fail_num;
    logic        gnt, rvalid, mem_req, mem_gnt, mem_rvalid, sig_valid, sig_ready;
    logic        sim_end, sim_succ, dump_done;

    sim_ctrl_dev #(.ADDR_W(32), .SIG_MAX_WORDS(4096)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .sig_valid_o(sig_valid), .sig_data_o(sig_data), .sig_ready_i(sig_ready),
        .sim_end_o(sim_end), .sim_succ_o(sim_succ), .fail_num_o(fail_num),
        .dump_done_o(dump_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before 300us");
        $fatal(1);
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    // ---------------- model state ----------------
    logic [31:0] ram [logic [31:0]];
    logic [31:0] exp_addr[$], exp_sig[$], got_addr[$], got_sig[$], want_q[$];
    logic [31:0] m_fail, m_begin, m_end;
    logic        m_end_f, m_succ, m_busy;
    int          done_cnt = 0;
    int          gnt_delay = 0, ready_stall = 0;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 32'h0;
    endfunction

    function automatic logic [31:0] be_apply(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_clear();
        m_fail = 32'h0; m_begin = 32'h0; m_end = 32'h0;
        m_end_f = 1'b0; m_succ = 1'b0; m_busy = 1'b0;
        exp_addr.delete(); exp_sig.delete(); got_addr.delete(); got_sig.delete();
    endtask

    // Expected word stream of a dump, from the programmed bounds and the RAM contents.
    task automatic start_model();
        logic [31:0] b, e, n;
        b = m_begin & ~32'h3;
        e = m_end & ~32'h3;
        if (e <= b) n = 32'h0;
        else n = (e - b) / 32'd4;
        if (n > 32'd4096) n = 32'd4096;
        for (int unsigned i = 0; i < n; i++) begin
            exp_addr.push_back(b + 32'(i * 4));
            exp_sig.push_back(ram_rd(b + 32'(i * 4)));
        end
        m_busy = (n != 32'h0);
    endtask

    // ---------------- RAM and sink responder ----------------
    logic        rv_pend;
    logic [31:0] rv_addr;
    int          gcnt, scnt;

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; sig_ready = 1'b0;
        rv_pend = 1'b0; rv_addr = 32'h0; gcnt = 0; scnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; sig_ready = 1'b0;
                rv_pend = 1'b0; gcnt = 0; scnt = 0;
            end else begin
                mem_rvalid = rv_pend;
                mem_rdata  = rv_pend ? ram_rd(rv_addr) : 32'h0;
                rv_pend    = 1'b0;
                mem_gnt    = 1'b0;
                if (mem_req) begin
                    if (gcnt >= gnt_delay) begin
                        mem_gnt = 1'b1; rv_pend = 1'b1; rv_addr = mem_addr; gcnt = 0;
                    end else gcnt++;
                end
                sig_ready = 1'b0;
                if (sig_valid) begin
                    if (scnt >= ready_stall) begin sig_ready = 1'b1; scnt = 0; end
                    else scnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        p_req, p_mwait, p_swait, p_done;
    logic [31:0] p_maddr, p_sdata;

    initial begin
        p_req = 1'b0; p_mwait = 1'b0; p_swait = 1'b0; p_done = 1'b0;
        p_maddr = 32'h0; p_sdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_flags", {26'd0, rvalid, mem_req, sig_valid, sim_end, sim_succ, dump_done}, 32'h0);
                chk("reset_data", rdata | mem_addr | sig_data | fail_num, 32'h0);
                p_req = 1'b0; p_mwait = 1'b0; p_swait = 1'b0; p_done = 1'b0;
            end else begin
                chk("gnt", {31'd0, gnt}, {31'd0, req});
                chk("rvalid", {31'd0, rvalid}, {31'd0, p_req});
                if (!rvalid) chk("rdata_idle", rdata, 32'h0);
                chk("sim_end", {31'd0, sim_end}, {31'd0, m_end_f});
                chk("sim_succ", {31'd0, sim_succ}, {31'd0, m_succ});
                chk("fail_num", fail_num, m_fail);
                if (p_mwait) begin
                    chk("mem_req_held", {31'd0, mem_req}, 32'h1);
                    chk("mem_addr_stable", mem_addr, p_maddr);
                end
                if (mem_req) begin
                    chk("mem_req_expected", 32'(exp_addr.size() != 0), 32'h1);
                    if (mem_gnt && exp_addr.size() != 0) begin
                        chk("mem_addr", mem_addr, exp_addr.pop_front());
                        got_addr.push_back(mem_addr);
                    end
                end
                if (p_swait) begin
                    chk("sig_valid_held", {31'd0, sig_valid}, 32'h1);
                    chk("sig_data_stable", sig_data, p_sdata);
                end
                if (sig_valid) begin
                    chk("sig_expected", 32'(exp_sig.size() != 0), 32'h1);
                    if (sig_ready && exp_sig.size() != 0) begin
                        chk("sig_data", sig_data, exp_sig.pop_front());
                        got_sig.push_back(sig_data);
                    end
                end
                if (dump_done) begin
                    done_cnt++;
                    chk("done_one_cycle", {31'd0, p_done}, 32'h0);
                    chk("done_after_stream", 32'(exp_sig.size()), 32'h0);
                    m_busy = 1'b0;
                end
                p_req   = req;
                p_mwait = mem_req && !mem_gnt;
                p_maddr = mem_addr;
                p_swait = sig_valid && !sig_ready;
                p_sdata = sig_data;
                p_done  = dump_done;
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic do_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = {27'd0, off, 2'b00}; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        case (off)
            3'd0: if (b[0]) begin
                if (d[0] && !m_end_f) begin m_end_f = 1'b1; m_succ = d[1]; end
                if (d[2] && !m_busy) start_model();
            end
            3'd1: m_fail = be_apply(m_fail, d, b);
            3'd2: if (!m_busy) m_begin = be_apply(m_begin, d, b);
            3'd3: if (!m_busy) m_end = be_apply(m_end, d, b);
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = {27'd0, off, 2'b00}; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        d = rdata;
    endtask

    task automatic wait_done(input string nm, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            @(posedge clk); #1;
        end
        chk(nm, 32'(done_cnt), 32'(target));
    endtask

    task automatic check_seq(input string nm, input logic [31:0] got[$], input logic [31:0] want[$]);
        chk({nm, "_len"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            chk(nm, (i < got.size()) ? got[i] : 32'hFFFF_FFFF, want[i]);
    endtask

    // ---------------- directed scenarios ----------------
    logic [31:0] rd;
    int          d0;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        ram[32'h100] = 32'hA;  ram[32'h104] = 32'hB;  ram[32'h108] = 32'hC;  ram[32'h10C] = 32'hD;
        ram[32'h400] = 32'h11; ram[32'h404] = 32'h22; ram[32'h408] = 32'h33; ram[32'h40C] = 32'h44;
        do_reset();
        bus_read(3'd4, rd);
        chk("rst_status", rd, 32'h0);

        // END with SUCC, then a second END write that must not touch SUCC
        bus_write(3'd0, 32'h3, 4'hF);
        chk("t1_end", {31'd0, sim_end}, 32'h1);
        chk("t1_succ", {31'd0, sim_succ}, 32'h1);
        bus_write(3'd0, 32'h1, 4'hF);
        chk("t1_succ_sticky", {31'd0, sim_succ}, 32'h1);

        // failing run, byte enables, unmapped offsets
        do_reset();
        bus_write(3'd1, 32'd5, 4'hF);
        bus_write(3'd0, 32'h1, 4'hF);
        chk("t2_fail_num", fail_num, 32'd5);
        chk("t2_succ", {31'd0, sim_succ}, 32'h0);
        bus_read(3'd4, rd);
        chk("t2_status", rd, 32'h4);
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd1, 32'h0000_AB00, 4'b0010);
        bus_read(3'd1, rd);
        chk("t2_be_merge", rd, 32'hFFFF_ABFF);
        bus_write(3'd6, 32'h1234_5678, 4'hF);
        bus_read(3'd0, rd);
        chk("t2_ctrl_read", rd, 32'h0);
        bus_read(3'd6, rd);
        chk("t2_unmapped_read", rd, 32'h0);

        // 3-word dump, polling STATUS until idle
        do_reset();
        gnt_delay = 0; ready_stall = 0;
        bus_write(3'd2, 32'h100, 4'hF);
        bus_write(3'd3, 32'h10C, 4'hF);
        d0 = done_cnt;
        bus_write(3'd0, 32'h4, 4'h1);
        rd = 32'h1;
        for (int i = 0; i < 60 && rd[0]; i++) bus_read(3'd4, rd);
        chk("t3_status", rd, 32'h2);
        chk("t3_done_count", 32'(done_cnt - d0), 32'h1);
        want_q = '{32'h100, 32'h104, 32'h108};
        check_seq("t3_addr", got_addr, want_q);
        want_q = '{32'hA, 32'hB, 32'hC};
        check_seq("t3_sig", got_sig, want_q);

        // same dump with slow grant and stalled sink; bound write while busy
        got_addr.delete(); got_sig.delete();
        gnt_delay = 3; ready_stall = 10;
        d0 = done_cnt;
        bus_write(3'd0, 32'h4, 4'h1);
        bus_write(3'd2, 32'h0000_0FF0, 4'hF);
        wait_done("t4_done", d0 + 1, 300);
        bus_read(3'd2, rd);
        chk("t4_begin_kept", rd, 32'h100);
        want_q = '{32'h100, 32'h104, 32'h108};
        check_seq("t4_addr", got_addr, want_q);
        want_q = '{32'hA, 32'hB, 32'hC};
        check_seq("t4_sig", got_sig, want_q);
        gnt_delay = 0; ready_stall = 0;

        // empty and inverted ranges complete the next cycle without traffic
        bus_write(3'd2, 32'h200, 4'hF);
        bus_write(3'd3, 32'h200, 4'hF);
        bus_write(3'd0, 32'h4, 4'h1);
        @(negedge clk);
        chk("t5_empty_done", {31'd0, dump_done}, 32'h1);
        chk("t5_empty_noreq", {31'd0, mem_req}, 32'h0);
        @(posedge clk); #1;
        bus_write(3'd3, 32'h1F0, 4'hF);
        bus_write(3'd0, 32'h4, 4'h1);
        @(negedge clk);
        chk("t5_inv_done", {31'd0, dump_done}, 32'h1);
        chk("t5_inv_nvalid", {31'd0, sig_valid}, 32'h0);
        @(posedge clk); #1;
        bus_read(3'd4, rd);
        chk("t5_status", rd, 32'h2);

        // reset in the middle of a 4-word dump, then a fresh dump
        do_reset();
        gnt_delay = 1;
        bus_write(3'd0, 32'h3, 4'h1);
        bus_write(3'd2, 32'h400, 4'hF);
        bus_write(3'd3, 32'h410, 4'hF);
        bus_write(3'd0, 32'h4, 4'h1);
        for (int i = 0; i < 100 && got_sig.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_pre_req", {31'd0, mem_req}, 32'h1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        model_clear();
        #1;
        chk("t6_async_req", {31'd0, mem_req}, 32'h0);
        chk("t6_async_addr", mem_addr, 32'h0);
        chk("t6_async_end", {31'd0, sim_end}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_done", 32'(done_cnt), 32'(d0));
        chk("t6_idle_req", {31'd0, mem_req}, 32'h0);
        bus_write(3'd2, 32'h408, 4'hF);
        bus_write(3'd3, 32'h410, 4'hF);
        bus_write(3'd0, 32'h4, 4'h1);
        wait_done("t6_done", d0 + 1, 100);
        want_q = '{32'h408, 32'h40C};
        check_seq("t6_addr", got_addr, want_q);
        want_q = '{32'h33, 32'h44};
        check_seq("t6_sig", got_sig, want_q);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
